bpm_gen: RTL and testbench

Parametrised tempo generator, successor to the single-rate BPM tick block. It converts a user BPM into a subdivision tick stream plus beat and bar strobes and position indices. The playback sequencer and metronome voice consume these outputs. The tick period is computed by an on-block sequential divider. Tempo changes apply glitch-free at the next tick boundary; play/pause and phase resync are supported.

---
 rtl/bpm_pkg.sv | 30 +++
 rtl/bpm_gen_divider.sv | 80 ++++++++
 rtl/bpm_gen.sv | 141 ++++++++++++++
 tb/tb_bpm_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bpm_pkg.sv
// Shared constants and helpers for the tempo generator.
//   tick_numer     : CLK_HZ*60, the numerator of every tick-period divide
//   default_period : tick period for the reset/default tempo, at elaboration
//   clog2_min1     : index width that never collapses to zero bits
//   div_state_e    : state encoding of the sequential divider
package bpm_pkg;

  typedef enum logic [0:0] {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  function automatic longint unsigned tick_numer(input int unsigned clk_hz);
    return 64'(clk_hz) * 64'd60;
  endfunction

  // A zero quotient would stall the counter, so it is clamped to one cycle.
  function automatic longint unsigned default_period(input int unsigned clk_hz,
                                                     input int unsigned dflt_bpm,
                                                     input int unsigned subdiv);
    longint unsigned p;
    p = tick_numer(clk_hz) / (64'(dflt_bpm) * 64'(subdiv));
    return (p == 64'd0) ? 64'd1 : p;
  endfunction

  function automatic int clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bpm_gen_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset : clock, asynchronous active-low reset
//   start      : sampled only in DIV_IDLE; latches dividend and divisor
//   dividend   : W-bit numerator
//   divisor    : W-bit denominator (zero yields an all-ones quotient)
//   done       : one-cycle pulse, quotient valid from this cycle on
//   quotient   : result of the most recent divide
//   state      : current FSM state (DIV_BUSY for exactly W cycles per divide)
module seq_divider
  import bpm_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output div_state_e   state
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] step_q;
  logic [W+1:0]  trial;
  logic [W-1:0]  rem_nxt, quo_nxt;

  // Shift the next dividend bit into the remainder and trial-subtract.
  // With a zero divisor the trial never goes negative, so every quotient
  // bit is set and the result is all ones without a special case.
  always_comb begin
    trial   = {1'b0, rem_q, quo_q[W-1]} - {2'b00, dvs_q};
    rem_nxt = {rem_q[W-2:0], quo_q[W-1]};
    quo_nxt = {quo_q[W-2:0], 1'b0};
    if (!trial[W+1]) begin
      rem_nxt = trial[W-1:0];
      quo_nxt = {quo_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= DIV_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      step_q   <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            step_q <= CW'(W);
            state  <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem_q  <= rem_nxt;
          quo_q  <= quo_nxt;
          step_q <= step_q - CW'(1);
          if (step_q == CW'(1)) begin
            state    <= DIV_IDLE;
            done     <= 1'b1;
            quotient <= quo_nxt;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bpm_gen.sv
// bpm_gen: tempo generator producing subdivision ticks, beat and bar strobes.
//   clk, reset : clock, asynchronous active-low reset
//   play       : 1 = run, 0 = pause (counter and indices hold)
//   sync       : one-cycle pulse, restart phase so the next tick is bar start
//   load_bpm   : request to load bpm
//   bpm        : requested tempo, 0 selects DEFAULT_BPM
//   ready      : load_bpm is accepted
//   tick/beat/bar : one-cycle strobes
//   sub_idx, beat_idx : indices of the current/last tick
//   period     : clock cycles per tick currently in use
//
// Load handshake: a load transfers on every rising edge where
// load_bpm && ready; ready then stays low for exactly CNT_W cycles while
// the period is divided out, and a load_bpm seen while ready is low is
// dropped, not queued.
module bpm_gen
  import bpm_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BPM_W         = 9,
  parameter int unsigned SUBDIV        = 2,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned DEFAULT_BPM   = 60,
  parameter int unsigned CNT_W         = 32,
  localparam int unsigned SUB_W        = clog2_min1(SUBDIV),
  localparam int unsigned BEAT_W       = clog2_min1(BEATS_PER_BAR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              sync,
  input  logic              load_bpm,
  input  logic [BPM_W-1:0]  bpm,
  output logic              ready,
  output logic              tick,
  output logic              beat,
  output logic              bar,
  output logic [SUB_W-1:0]  sub_idx,
  output logic [BEAT_W-1:0] beat_idx,
  output logic [CNT_W-1:0]  period
);

  localparam longint unsigned NUMER = tick_numer(CLK_HZ);
  localparam logic [CNT_W-1:0] NUMER_C    = CNT_W'(NUMER);
  localparam logic [CNT_W-1:0] DEF_PERIOD =
    CNT_W'(default_period(CLK_HZ, DEFAULT_BPM, SUBDIV));

  if ((NUMER >> CNT_W) != 64'd0) begin : g_numer_too_wide
    $error("bpm_gen: CLK_HZ*60 does not fit in CNT_W bits");
  end
  if (SUBDIV < 1 || BEATS_PER_BAR < 1 || DEFAULT_BPM < 1) begin : g_bad_param
    $error("bpm_gen: SUBDIV, BEATS_PER_BAR and DEFAULT_BPM must be >= 1");
  end

  div_state_e       div_state;
  logic             div_done;
  logic [CNT_W-1:0] div_quo, div_result;
  logic [CNT_W-1:0] eff_bpm, divisor;

  logic [CNT_W-1:0]  cnt;
  logic              pend_valid;
  logic [CNT_W-1:0]  pend_period;
  logic [CNT_W-1:0]  reload_period;
  logic [SUB_W-1:0]  nxt_sub;
  logic [BEAT_W-1:0] nxt_beat;

  assign ready      = (div_state == DIV_IDLE);
  assign eff_bpm    = (bpm == '0) ? CNT_W'(DEFAULT_BPM) : CNT_W'(bpm);
  assign divisor    = eff_bpm * CNT_W'(SUBDIV);
  assign div_result = (div_quo == '0) ? CNT_W'(1) : div_quo;

  // A divide finishing on the reload edge is used directly, so a result
  // counts as pending from the cycle ready returns high.
  assign reload_period = div_done   ? div_result  :
                         pend_valid ? pend_period : period;

  seq_divider #(.W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (load_bpm && ready),
    .dividend (NUMER_C),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (div_quo),
    .state    (div_state)
  );

  // nxt_sub/nxt_beat hold the indices the next tick will carry; the
  // sub_idx/beat_idx outputs are copied from them when the tick fires.
  // Sync zeroes the counter, so the tick comes one cycle after the counter
  // has been seen at zero with play high, exactly like a normal reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= DEF_PERIOD - CNT_W'(1);
      period      <= DEF_PERIOD;
      pend_valid  <= 1'b0;
      pend_period <= DEF_PERIOD;
      nxt_sub     <= '0;
      nxt_beat    <= '0;
      sub_idx     <= '0;
      beat_idx    <= '0;
      tick        <= 1'b0;
      beat        <= 1'b0;
      bar         <= 1'b0;
    end else begin
      tick <= 1'b0;
      beat <= 1'b0;
      bar  <= 1'b0;
      if (div_done) begin
        pend_valid  <= 1'b1;
        pend_period <= div_result;
      end
      if (sync) begin
        cnt      <= '0;
        nxt_sub  <= '0;
        nxt_beat <= '0;
      end else if (play) begin
        if (cnt == '0) begin
          cnt        <= reload_period - CNT_W'(1);
          period     <= reload_period;
          pend_valid <= 1'b0;
          tick       <= 1'b1;
          beat       <= (nxt_sub == '0);
          bar        <= (nxt_sub == '0) && (nxt_beat == '0);
          sub_idx    <= nxt_sub;
          beat_idx   <= nxt_beat;
          if (nxt_sub == SUB_W'(SUBDIV - 1)) begin
            nxt_sub  <= '0;
            nxt_beat <= (nxt_beat == BEAT_W'(BEATS_PER_BAR - 1)) ?
                        '0 : nxt_beat + BEAT_W'(1);
          end else begin
            nxt_sub <= nxt_sub + SUB_W'(1);
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpm_gen.sv
// Bench for bpm_gen with CLK_HZ=1000, SUBDIV=2, BEATS_PER_BAR=4 (period 500).
// Directed phases push hand-computed tick events (cycle, indices, strobes,
// period) into exp_q; a monitor pops one entry per observed tick.
module tb_bpm_gen;

  localparam int EW = 53; // {cyc[15:0], sub, beat_idx[1:0], beat, bar, period[31:0]}

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        play     = 1'b0;
  logic        sync     = 1'b0;
  logic        load_bpm = 1'b0;
  logic [8:0]  bpm      = '0;
  logic        ready, tick, beat, bar;
  logic [0:0]  sub_idx;
  logic [1:0]  beat_idx;
  logic [31:0] period;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  bpm_gen #(
    .CLK_HZ(1000), .BPM_W(9), .SUBDIV(2), .BEATS_PER_BAR(4),
    .DEFAULT_BPM(60), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .sync(sync),
    .load_bpm(load_bpm), .bpm(bpm), .ready(ready), .tick(tick),
    .beat(beat), .bar(bar), .sub_idx(sub_idx), .beat_idx(beat_idx),
    .period(period)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_tick(input int at, input int s, input int b, input int p);
    logic be, ba;
    be = (s == 0);
    ba = be && (b == 0);
    exp_q.push_back({16'(at), 1'(s), 2'(b), be, ba, 32'(p)});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [8:0] value);
    load_bpm = 1'b1;
    bpm      = value;
    @(negedge clk);
    load_bpm = 1'b0;
    bpm      = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tick"},     tick,     0);
    check({tag, "_beat"},     beat,     0);
    check({tag, "_bar"},      bar,      0);
    check({tag, "_sub_idx"},  sub_idx,  0);
    check({tag, "_beat_idx"}, beat_idx, 0);
    check({tag, "_ready"},    ready,    1);
    check({tag, "_period"},   period,   500);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] a, e;
    if (reset && tick) begin
      a = {16'(cyc), sub_idx, beat_idx, beat, bar, period};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL tick_unexpected: tick at cycle %0d sub=%0d beat_idx=%0d, none expected",
                 cyc, sub_idx, beat_idx);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL tick: got cyc=%0d sub=%0d bidx=%0d beat=%0b bar=%0b period=%0d, expected cyc=%0d sub=%0d bidx=%0d beat=%0b bar=%0b period=%0d",
                   a[52:37], a[36], a[35:34], a[33], a[32], a[31:0],
                   e[52:37], e[36], e[35:34], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #2 reset = 1'b0;
    play = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset0");

    // Phase A: default tempo, 500-cycle ticks, bar every 4000 cycles.
    for (int k = 0; k < 9; k++)
      expect_tick(500 * (k + 1), k % 2, (k / 2) % 4, 500);
    reset = 1'b1;

    // Phase B: load 120 BPM mid-interval; 250 takes over at the 5000 reload.
    wait_cyc(4700);
    expect_tick(5000, 1, 0, 250);
    for (int k = 1; k < 8; k++)
      expect_tick(5000 + 250 * k, (k + 1) % 2, ((k + 1) / 2) % 4, 250);
    pulse_load(9'd120);
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("load120_ready_low_cycles", n, 32);

    // Phase C: bpm=0 selects default; a second load while busy is dropped.
    wait_cyc(6800);
    expect_tick(7000, 1, 0, 500);
    expect_tick(7500, 0, 1, 500);
    expect_tick(8000, 1, 1, 500);
    expect_tick(8500, 0, 2, 500);
    pulse_load(9'd0);
    wait_cyc(6810);
    check("ready_low_during_divide", ready, 0);
    pulse_load(9'd120);
    wait_cyc(6833);
    check("ready_back_after_divide", ready, 1);

    // Phase D: 137-cycle pause mid-interval delays the next tick by 137.
    wait_cyc(8600);
    expect_tick(9137, 1, 2, 500);
    expect_tick(9637, 0, 3, 500);
    expect_tick(10137, 1, 3, 500);
    expect_tick(10637, 0, 0, 500);
    play = 1'b0;
    wait_cyc(8737);
    play = 1'b1;

    // Phase E: sync while at sub 1 / beat 2 restarts at bar start.
    expect_tick(11137, 1, 0, 500);
    expect_tick(11637, 0, 1, 500);
    expect_tick(12137, 1, 1, 500);
    expect_tick(12637, 0, 2, 500);
    expect_tick(13137, 1, 2, 500);
    wait_cyc(13300);
    check("pre_sync_sub_idx", sub_idx, 1);
    check("pre_sync_beat_idx", beat_idx, 2);
    expect_tick(13302, 0, 0, 500);
    expect_tick(13802, 1, 0, 500);
    expect_tick(14302, 0, 1, 500);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;

    // Phase F: reset during an active divide, mid-bar.
    wait_cyc(14400);
    pulse_load(9'd120);
    wait_cyc(14410);
    check("busy_before_reset", ready, 0);
    check("queue_drained_before_reset", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check_reset_state("reset_mid");
    repeat (3) @(negedge clk);
    expect_tick(500, 0, 0, 500);
    expect_tick(1000, 1, 0, 500);
    expect_tick(1500, 0, 1, 500);
    reset = 1'b1;
    wait_cyc(1600);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
